// File: rtl/ctl_diag_pkg.sv
// Shared types and constants for the CTL diagnostic function sequencer.
// Holds the FSM state enum, function-code constants and the class decoder.
package ctl_diag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_LOAD,
        ST_READ,
        ST_BURST,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        CLS_OTHER,
        CLS_LOAD,
        CLS_STEP,
        CLS_READ,
        CLS_BAD
    } func_cls_e;

    localparam logic [2:0] FUNC_07X      = 3'b111;
    localparam logic [6:0] FUNC_STEP     = 7'o077;
    localparam logic [6:0] FUNC_CLRERR   = 7'o070;
    localparam logic       FUNC_READ_MSB = 1'b1;

    // f[6] is DS0, f[2:0] is DS[4:6].
    // 077 is tested first so it never lands in the 07x load class.
    function automatic func_cls_e classify(
        input logic [6:0] f,
        input int         n_ld,
        input int         n_rd
    );
        int idx;
        idx = int'(f[2:0]);
        if (f == FUNC_STEP)
            return CLS_STEP;
        if (f[6] != FUNC_READ_MSB && f[5:3] == FUNC_07X)
            return (idx < n_ld) ? CLS_LOAD : CLS_BAD;
        if (f[6] == FUNC_READ_MSB)
            return (idx < n_rd) ? CLS_READ : CLS_BAD;
        return CLS_OTHER;
    endfunction

endpackage

// File: rtl/ctl_diag_sync.sv
// Strobe synchroniser with rising-edge detect, shared by EBUS slaves.
// Ports: clk_i, rst_ni (async low), async_i in; sync_o level, rise_o pulse out.
module ctl_diag_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/ctl_diag_seq.sv
// CTL diagnostic function sequencer: strobe sync, DS decode, register load,
// registered EBUS readback and counted EBOX step burst (function 077).
// Ports: CLK, RESET_N (async low), diag_strobe, ds[6:0] (DS0 = bit 6),
//   ebus_in, rd_src in; ldreg, ebus_out, ebus_drv, step_clk, busy, ack,
//   bad_func out. Macro CTL_DIAG_PARITY_EN adds ebus_par_in/ebus_par_out.
module ctl_diag_seq
    import ctl_diag_pkg::*;
#(
    parameter int DATA_W      = 5,
    parameter int N_LDREG     = 4,
    parameter int N_RDGRP     = 8,
    parameter int BURST_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       diag_strobe,
    input  logic [6:0]                 ds,
    input  logic [DATA_W-1:0]          ebus_in,
`ifdef CTL_DIAG_PARITY_EN
    input  logic                       ebus_par_in,
    output logic                       ebus_par_out,
`endif
    input  logic [N_RDGRP*DATA_W-1:0]  rd_src,
    output logic [N_LDREG*DATA_W-1:0]  ldreg,
    output logic [DATA_W-1:0]          ebus_out,
    output logic                       ebus_drv,
    output logic                       step_clk,
    output logic                       busy,
    output logic                       ack,
    output logic                       bad_func
);

    state_e             state_q, state_d;
    func_cls_e          cls;
    logic [6:0]         ds_q;
    logic [BURST_W-1:0] cnt_q, cnt_d, cnt_ld;
    logic               ph_q, ph_d;
    logic               bad_q, bad_d;
    logic [DATA_W-1:0]  out_q, rd_sel;
    logic [DATA_W-1:0]  ldreg_q [N_LDREG];
    logic               stb_p, stb_lvl, cap_ds;
    logic               ld_we, rd_ld, bad_set, bad_clr, par_ok;

    ctl_diag_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .async_i (diag_strobe),
        .sync_o  (stb_lvl),
        .rise_o  (stb_p)
    );

    assign cls    = classify(ds_q, N_LDREG, N_RDGRP);
    assign cnt_ld = BURST_W'(ebus_in);
    assign cap_ds = stb_p && (state_q == ST_IDLE);
    assign busy   = (state_q != ST_IDLE);

`ifdef CTL_DIAG_PARITY_EN
    // Odd parity expected over data plus parity bit.
    assign par_ok = ^{ebus_in, ebus_par_in};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        rd_sel = '0;
        for (int g = 0; g < N_RDGRP; g++)
            if (ds_q[2:0] == 3'(g))
                rd_sel = rd_src[g*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        bad_d    = bad_q;
        ld_we    = 1'b0;
        rd_ld    = 1'b0;
        bad_set  = 1'b0;
        bad_clr  = 1'b0;
        step_clk = 1'b0;
        ebus_drv = 1'b0;
        ack      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (stb_p)
                    state_d = ST_DECODE;
            end
            ST_DECODE: begin
                unique case (cls)
                    CLS_LOAD: state_d = ST_LOAD;
                    CLS_STEP: begin
                        // Zero count skips BURST so ack lands 2 cycles in.
                        cnt_d   = cnt_ld;
                        ph_d    = 1'b0;
                        state_d = (cnt_ld == '0) ? ST_DONE : ST_BURST;
                    end
                    CLS_READ: begin
                        rd_ld   = 1'b1;
                        state_d = ST_READ;
                    end
                    CLS_BAD: begin
                        bad_set = 1'b1;
                        state_d = ST_DONE;
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_LOAD: begin
                state_d = ST_DONE;
                if (par_ok) begin
                    ld_we = 1'b1;
                    if (ds_q == FUNC_CLRERR && ebus_in[0])
                        bad_clr = 1'b1;
                end else begin
                    bad_set = 1'b1;
                end
            end
            ST_READ: begin
                if (stb_lvl)
                    ebus_drv = 1'b1;
                else
                    state_d = ST_DONE;
            end
            ST_BURST: begin
                // ph_q=0: pulse cycle, ph_q=1: gap cycle.
                if (!ph_q) begin
                    step_clk = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    ph_d     = 1'b1;
                end else begin
                    ph_d = 1'b0;
                    if (cnt_q == '0)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ack     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (stb_p && state_q != ST_IDLE)
            bad_set = 1'b1;
        // A new error wins over a same-cycle clear.
        if (bad_set)
            bad_d = 1'b1;
        else if (bad_clr)
            bad_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            ds_q    <= '0;
            cnt_q   <= '0;
            ph_q    <= 1'b0;
            bad_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            bad_q   <= bad_d;
            if (cap_ds)
                ds_q <= ds;
            if (rd_ld)
                out_q <= rd_sel;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_LDREG; i++)
                ldreg_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_LDREG; i++)
                if (ld_we && ds_q[2:0] == 3'(i))
                    ldreg_q[i] <= ebus_in;
        end
    end

`ifdef CTL_DIAG_PARITY_EN
    logic par_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            par_q <= 1'b0;
        else if (rd_ld)
            par_q <= ~^rd_sel;
    end

    assign ebus_par_out = par_q;
`endif

    for (genvar i = 0; i < N_LDREG; i++) begin : g_ld
        assign ldreg[i*DATA_W +: DATA_W] = ldreg_q[i];
    end

    assign ebus_out = out_q;
    assign bad_func = bad_q;

endmodule

// File: tb/tb_ctl_diag_seq.sv
// Self-checking bench for ctl_diag_seq: directed and random functions
// compared with a function-level reference model.
module tb_ctl_diag_seq;

    localparam int DATA_W      = 5;
    localparam int N_LDREG     = 4;
    localparam int N_RDGRP     = 8;
    localparam int BURST_W     = 8;
    localparam int SYNC_STAGES = 2;

    logic                      CLK;
    logic                      RESET_N;
    logic                      diag_strobe;
    logic [6:0]                ds;
    logic [DATA_W-1:0]         ebus_in;
    logic [N_RDGRP*DATA_W-1:0] rd_src;
    logic [N_LDREG*DATA_W-1:0] ldreg;
    logic [DATA_W-1:0]         ebus_out;
    logic                      ebus_drv, step_clk, busy, ack, bad_func;
`ifdef CTL_DIAG_PARITY_EN
    logic                      ebus_par_in, ebus_par_out;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] m_ld [N_LDREG];
    logic              m_bad;
    logic [DATA_W-1:0] m_out;
    bit                par_err;

    int                r_b0, r_a0, r_acks, r_post_busy, r_timeout;
    int                r_drv_first, r_drv_last, r_drv_cnt, r_drv_var;
    logic [DATA_W-1:0] r_drv_val;
    int                r_pulses [$];

    ctl_diag_seq #(
        .DATA_W      (DATA_W),
        .N_LDREG     (N_LDREG),
        .N_RDGRP     (N_RDGRP),
        .BURST_W     (BURST_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .diag_strobe (diag_strobe),
        .ds          (ds),
        .ebus_in     (ebus_in),
`ifdef CTL_DIAG_PARITY_EN
        .ebus_par_in (ebus_par_in),
        .ebus_par_out(ebus_par_out),
`endif
        .rd_src      (rd_src),
        .ldreg       (ldreg),
        .ebus_out    (ebus_out),
        .ebus_drv    (ebus_drv),
        .step_clk    (step_clk),
        .busy        (busy),
        .ack         (ack),
        .bad_func    (bad_func)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [N_LDREG*DATA_W-1:0] m_ldreg();
        logic [N_LDREG*DATA_W-1:0] v;
        for (int i = 0; i < N_LDREG; i++)
            v[i*DATA_W +: DATA_W] = m_ld[i];
        return v;
    endfunction

    // Strobe is high for sample intervals [0,hold) and, if ovl>0,
    // again for [ovl,ovl+3) to provoke an overlapping request.
    task automatic run_func(input logic [6:0] f, input logic [DATA_W-1:0] din,
                            input int hold, input int ovl);
        int cyc;
        bit fin;
        r_b0 = -1; r_a0 = -1; r_acks = 0; r_post_busy = -1; r_timeout = 0;
        r_drv_first = -1; r_drv_last = -1; r_drv_cnt = 0; r_drv_var = 0;
        r_drv_val = '0;
        r_pulses.delete();
        ds = f;
        ebus_in = din;
`ifdef CTL_DIAG_PARITY_EN
        ebus_par_in = par_err ? ^din : ~^din;
`endif
        diag_strobe = 1'b1;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            tick();
            cyc++;
            if (busy && r_b0 < 0) r_b0 = cyc;
            if (r_a0 >= 0 && cyc == r_a0 + 1) r_post_busy = int'(busy);
            if (ack) begin
                r_acks++;
                if (r_a0 < 0) r_a0 = cyc;
            end
            if (step_clk) r_pulses.push_back(cyc);
            if (ebus_drv) begin
                if (r_drv_first < 0) begin
                    r_drv_first = cyc;
                    r_drv_val = ebus_out;
                end else if (ebus_out !== r_drv_val) begin
                    r_drv_var = 1;
                end
                r_drv_last = cyc;
                r_drv_cnt++;
            end
            diag_strobe = (cyc < hold) || (ovl > 0 && cyc >= ovl && cyc < ovl + 3);
            if (r_a0 >= 0 && cyc >= r_a0 + 1) fin = 1'b1;
            if (cyc >= 200) begin
                r_timeout = 1;
                fin = 1'b1;
            end
        end
        diag_strobe = 1'b0;
        repeat (SYNC_STAGES + 3) tick();
    endtask

    task automatic do_func(input string tag, input logic [6:0] f,
                           input logic [DATA_W-1:0] din, input int hold,
                           input int ovl);
        int fi, idx, kind, stb, n, exp_ack, d_last;
        run_func(f, din, hold, ovl);
        fi  = int'(f);
        idx = fi % 8;
        // kind: 0 other, 1 load, 2 step, 3 read, 4 bad index
        if (fi == 8'o77) kind = 2;
        else if (fi / 8 == 7) kind = (idx < N_LDREG) ? 1 : 4;
        else if (fi >= 64) kind = (idx < N_RDGRP) ? 3 : 4;
        else kind = 0;
        stb    = SYNC_STAGES;
        n      = (kind == 2) ? int'(din) : 0;
        d_last = hold + SYNC_STAGES - 1;
        case (kind)
            1:       exp_ack = stb + 3;
            2:       exp_ack = stb + 2 + 2 * n;
            3:       exp_ack = d_last + 2;
            default: exp_ack = stb + 2;
        endcase
        if (kind == 1) begin
            if (!par_err) begin
                m_ld[idx] = din;
                if (fi == 8'o70 && din[0]) m_bad = 1'b0;
            end else begin
                m_bad = 1'b1;
            end
        end
        if (kind == 4) m_bad = 1'b1;
        if (kind == 3) m_out = rd_src[idx*DATA_W +: DATA_W];
        if (ovl > 0) m_bad = 1'b1;

        chk({tag, "_timeout"}, 64'(r_timeout), 64'(0));
        chk({tag, "_busy_lat"}, 64'(r_b0), 64'(stb + 1));
        chk({tag, "_ack_at"}, 64'(r_a0), 64'(exp_ack));
        chk({tag, "_ack_cnt"}, 64'(r_acks), 64'(1));
        chk({tag, "_busy_after"}, 64'(r_post_busy), 64'(0));
        chk({tag, "_npulse"}, 64'(r_pulses.size()), 64'(n));
        for (int k = 0; k < n && k < r_pulses.size(); k++)
            chk({tag, "_pulse_at"}, 64'(r_pulses[k]), 64'(stb + 2 + 2 * k));
        if (kind == 3) begin
            chk({tag, "_drv_first"}, 64'(r_drv_first), 64'(stb + 2));
            chk({tag, "_drv_last"}, 64'(r_drv_last), 64'(d_last));
            chk({tag, "_drv_val"}, 64'(r_drv_val), 64'(m_out));
            chk({tag, "_drv_stable"}, 64'(r_drv_var), 64'(0));
        end else begin
            chk({tag, "_drv_cnt"}, 64'(r_drv_cnt), 64'(0));
        end
        chk({tag, "_ebus_out"}, 64'(ebus_out), 64'(m_out));
        chk({tag, "_ldreg"}, 64'(ldreg), 64'(m_ldreg()));
        chk({tag, "_bad_func"}, 64'(bad_func), 64'(m_bad));
`ifdef CTL_DIAG_PARITY_EN
        chk({tag, "_par_out"}, 64'(ebus_par_out), 64'(~^m_out));
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_step_clk"}, 64'(step_clk), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ack"}, 64'(ack), 64'(0));
        chk({tag, "_bad_func"}, 64'(bad_func), 64'(0));
        chk({tag, "_ebus_drv"}, 64'(ebus_drv), 64'(0));
        chk({tag, "_ebus_out"}, 64'(ebus_out), 64'(0));
        chk({tag, "_ldreg"}, 64'(ldreg), 64'(0));
    endtask

    initial begin
        int np, cyc, sel, hold;
        logic [6:0]        f;
        logic [DATA_W-1:0] din;

        RESET_N = 1'b0;
        diag_strobe = 1'b0;
        ds = '0;
        ebus_in = '0;
        rd_src = '0;
        par_err = 1'b0;
`ifdef CTL_DIAG_PARITY_EN
        ebus_par_in = 1'b1;
`endif
        for (int i = 0; i < N_LDREG; i++) m_ld[i] = '0;
        m_bad = 1'b0;
        m_out = '0;

        repeat (3) tick();
        chk_zero("reset");
        RESET_N = 1'b1;
        repeat (3) tick();
        chk("idle_busy", 64'(busy), 64'(0));

        rd_src = 40'({$urandom(), $urandom()});
        do_func("load072", 7'o072, 5'b10110, 2, 0);

        rd_src[5*DATA_W +: DATA_W] = 5'b01011;
        do_func("read105", 7'o105, 5'b00000, 6, 0);

        do_func("burst3", 7'o077, 5'd3, 2, 0);
        do_func("burst0", 7'o077, 5'd0, 2, 0);
        do_func("other013", 7'o013, 5'b11111, 2, 0);
        do_func("badidx075", 7'o075, 5'b00100, 2, 0);
        do_func("clr070", 7'o070, 5'b00001, 2, 0);
        do_func("ovl_burst10", 7'o077, 5'd10, 2, 8);
        do_func("noclr070", 7'o070, 5'b11110, 2, 0);
        do_func("clr070b", 7'o070, 5'b00011, 2, 0);
        do_func("burst31", 7'o077, 5'd31, 1, 0);

`ifdef CTL_DIAG_PARITY_EN
        par_err = 1'b1;
        do_func("par_bad", 7'o071, 5'b10101, 2, 0);
        par_err = 1'b0;
        do_func("par_clr", 7'o070, 5'b00001, 2, 0);
        rd_src[0 +: DATA_W] = 5'b00001;
        do_func("par_rd", 7'o100, 5'b00000, 5, 0);
        chk("par_rd_00001", 64'(ebus_par_out), 64'(0));
`endif

        for (int it = 0; it < 30; it++) begin
            rd_src = 40'({$urandom(), $urandom()});
            sel = $urandom_range(0, 5);
            din = DATA_W'($urandom_range(0, 31));
            hold = $urandom_range(1, 3);
            case (sel)
                0: f = 7'(56 + $urandom_range(0, N_LDREG - 1));
                1: begin
                    f = 7'o077;
                    din = DATA_W'($urandom_range(0, 12));
                end
                2: begin
                    f = 7'(64 + $urandom_range(0, 63));
                    hold = $urandom_range(4, 7);
                end
                3: f = 7'(56 + $urandom_range(N_LDREG, 6));
                4: f = 7'($urandom_range(0, 55));
                default: f = 7'o070;
            endcase
            do_func("rand", f, din, hold, 0);
        end

        // Reset in the middle of a 10-step burst.
        ds = 7'o077;
        ebus_in = 5'd10;
        diag_strobe = 1'b1;
        np = 0;
        cyc = 0;
        while (np < 3 && cyc < 100) begin
            tick();
            cyc++;
            if (cyc == 1) diag_strobe = 1'b0;
            if (step_clk) np++;
        end
        chk("rst_pre_pulses", 64'(np), 64'(3));
        RESET_N = 1'b0;
        #1;
        chk_zero("rst_mid");
        np = 0;
        repeat (3) begin
            tick();
            if (step_clk) np++;
        end
        RESET_N = 1'b1;
        repeat (6) begin
            tick();
            if (step_clk) np++;
        end
        chk("rst_no_pulses", 64'(np), 64'(0));
        for (int i = 0; i < N_LDREG; i++) m_ld[i] = '0;
        m_bad = 1'b0;
        m_out = '0;
        chk_zero("rst_after");
        do_func("post_rst_load", 7'o073, 5'b01101, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
